// File: rtl/tmds_encoder_hdmi.sv
// tmds_encoder_hdmi
//   Multi-channel HDMI TMDS encoder. Each channel produces one 10-bit symbol
//   per pixel clock: DVI video coding with a running disparity bias, control
//   codes, video and data-island guard bands, and TERC4 data-island coding.
//   An optional checker watches the HDMI period sequence (control, preamble
//   and guard bands, video, data island) and raises a sticky error flag.
//
// Parameters
//   NUM_CH : number of channels; channel k takes the guard-band role k mod 3
//   PIPE   : output register stages, 1 or 2
//   CHECK  : 1 enables the sequence checker, 0 holds o_seq_err low
//
// Ports
//   i_clk      pixel clock
//   i_rst      synchronous active-high reset
//   i_mode     0=CTRL 1=VIDEO 2=VIDEO_GB 3=ISLAND_GB 4=TERC4 5..7 reserved
//   i_data     8 bits per channel, channel k at [8k+7:8k]
//   i_ctrl     2 bits per channel (ch0 = {vsync,hsync})
//   i_aux      4-bit TERC4 nibble per channel
//   o_tmds     10-bit symbol per channel, bit 0 transmitted first
//   o_seq_err  sticky sequence-violation flag, same latency as o_tmds
module tmds_encoder_hdmi #(
  parameter int NUM_CH = 3,
  parameter int PIPE   = 1,
  parameter int CHECK  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2:0]           i_mode,
  input  logic [8*NUM_CH-1:0]  i_data,
  input  logic [2*NUM_CH-1:0]  i_ctrl,
  input  logic [4*NUM_CH-1:0]  i_aux,
  output logic [10*NUM_CH-1:0] o_tmds,
  output logic                 o_seq_err
);

  localparam logic [2:0] M_CTRL  = 3'd0;
  localparam logic [2:0] M_VIDEO = 3'd1;
  localparam logic [2:0] M_VGB   = 3'd2;
  localparam logic [2:0] M_IGB   = 3'd3;
  localparam logic [2:0] M_TERC4 = 3'd4;

  localparam logic [9:0] SYM_RST   = 10'b1101010100;
  localparam logic [9:0] SYM_GB_HI = 10'b1011001100;
  localparam logic [9:0] SYM_GB_LO = 10'b0100110011;

  localparam logic [2:0] S_CTRL      = 3'd0;
  localparam logic [2:0] S_VGB       = 3'd1;
  localparam logic [2:0] S_VIDEO     = 3'd2;
  localparam logic [2:0] S_IGB_LEAD  = 3'd3;
  localparam logic [2:0] S_ISLAND    = 3'd4;
  localparam logic [2:0] S_IGB_TRAIL = 3'd5;

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("tmds_encoder_hdmi: PIPE must be 1 or 2");
  end

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_sym = 10'b1101010100;
      2'b01:   ctrl_sym = 10'b0010101011;
      2'b10:   ctrl_sym = 10'b0101010100;
      default: ctrl_sym = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] d);
    case (d)
      4'h0:    terc4_sym = 10'b1010011100;
      4'h1:    terc4_sym = 10'b1001100011;
      4'h2:    terc4_sym = 10'b1011100100;
      4'h3:    terc4_sym = 10'b1011100010;
      4'h4:    terc4_sym = 10'b0101110001;
      4'h5:    terc4_sym = 10'b0100011110;
      4'h6:    terc4_sym = 10'b0110001110;
      4'h7:    terc4_sym = 10'b0100111100;
      4'h8:    terc4_sym = 10'b1011001100;
      4'h9:    terc4_sym = 10'b0100111001;
      4'hA:    terc4_sym = 10'b0110011100;
      4'hB:    terc4_sym = 10'b1011000110;
      4'hC:    terc4_sym = 10'b1010001110;
      4'hD:    terc4_sym = 10'b1001110001;
      4'hE:    terc4_sym = 10'b0101100011;
      default: terc4_sym = 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    ones8 = 4'd0;
    for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b000, d[i]};
  endfunction

  // Returns {next_bias[4:0], symbol[9:0]} for one video byte.
  function automatic logic [14:0] video_enc(input logic [7:0] d,
                                            input logic signed [4:0] bias);
    logic [8:0]        q_m;
    logic [3:0]        n1;
    logic              use_xnor;
    logic signed [5:0] bal;
    logic signed [5:0] b6;
    logic signed [5:0] nxt;
    logic [9:0]        sym;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q_m[0]   = d[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
    q_m[8] = ~use_xnor;
    // balance = N1 - N0 of q_m[7:0] = 2*N1 - 8
    bal = $signed({1'b0, ones8(q_m[7:0]), 1'b0}) - 6'sd8;
    b6  = 6'(bias);
    if (bias == 5'sd0 || bal == 6'sd0) begin
      sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      nxt = q_m[8] ? (b6 + bal) : (b6 - bal);
    end else if (bias[4] == bal[5]) begin
      sym = {1'b1, q_m[8], ~q_m[7:0]};
      nxt = b6 + (q_m[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      sym = {1'b0, q_m[8], q_m[7:0]};
      nxt = b6 + bal - (q_m[8] ? 6'sd0 : 6'sd2);
    end
    video_enc = {nxt[4:0], sym};
  endfunction

  logic [10*NUM_CH-1:0] sym_c;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int ROLE = k % 3;
    logic signed [4:0] bias;
    logic [14:0]       vid;
    logic [9:0]        sym;

    always_comb begin
      vid = video_enc(i_data[8*k +: 8], bias);
      sym = ctrl_sym(i_ctrl[2*k +: 2]);
      case (i_mode)
        M_VIDEO: sym = vid[9:0];
        M_VGB:   sym = (ROLE == 1) ? SYM_GB_LO : SYM_GB_HI;
        M_IGB:   sym = (ROLE == 0) ? terc4_sym({2'b11, i_ctrl[2*k +: 2]}) : SYM_GB_LO;
        M_TERC4: sym = terc4_sym(i_aux[4*k +: 4]);
        default: ;
      endcase
    end

    // Disparity only carries across consecutive video cycles.
    always_ff @(posedge i_clk) begin
      if (i_rst)                  bias <= 5'sd0;
      else if (i_mode == M_VIDEO) bias <= $signed(vid[14:10]);
      else                        bias <= 5'sd0;
    end

    assign sym_c[10*k +: 10] = sym;
  end

  logic seq_err_p0;

  if (CHECK != 0) begin : g_chk
    logic [2:0] state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [1:0] n, n_nx;
    logic [9:0] len, len_nx;
    logic       err;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      n_nx     = n;
      len_nx   = len;
      err      = 1'b0;
      case (state)
        S_CTRL: begin
          case (i_mode)
            M_CTRL: if (cnt != 4'd8) cnt_nx = cnt + 4'd1;
            M_VGB, M_IGB: begin
              if (cnt == 4'd8) begin
                state_nx = (i_mode == M_VGB) ? S_VGB : S_IGB_LEAD;
                n_nx     = 2'd1;
              end else begin
                err = 1'b1;
              end
            end
            default: err = 1'b1;
          endcase
        end
        S_VGB: begin
          if (n == 2'd1 && i_mode == M_VGB)        n_nx = 2'd2;
          else if (n == 2'd2 && i_mode == M_VIDEO) state_nx = S_VIDEO;
          else                                     err = 1'b1;
        end
        S_VIDEO: begin
          if (i_mode == M_VIDEO) begin
            state_nx = S_VIDEO;
          end else if (i_mode == M_CTRL) begin
            state_nx = S_CTRL;
            cnt_nx   = 4'd1;
          end else begin
            err = 1'b1;
          end
        end
        S_IGB_LEAD: begin
          if (n == 2'd1 && i_mode == M_IGB) begin
            n_nx = 2'd2;
          end else if (n == 2'd2 && i_mode == M_TERC4) begin
            state_nx = S_ISLAND;
            len_nx   = 10'd1;
          end else begin
            err = 1'b1;
          end
        end
        S_ISLAND: begin
          if (i_mode == M_TERC4) begin
            len_nx = len + 10'd1;
            // the incremented length would exceed 576
            if (len >= 10'd576) err = 1'b1;
          end else if (i_mode == M_IGB && len[4:0] == 5'd0) begin
            state_nx = S_IGB_TRAIL;
            n_nx     = 2'd1;
          end else begin
            err = 1'b1;
          end
        end
        S_IGB_TRAIL: begin
          if (n == 2'd1 && i_mode == M_IGB) begin
            n_nx = 2'd2;
          end else if (n == 2'd2 && i_mode == M_CTRL) begin
            state_nx = S_CTRL;
            cnt_nx   = 4'd1;
          end else begin
            err = 1'b1;
          end
        end
        default: err = 1'b1;
      endcase
      // Resync: the offending cycle itself counts as control if it was one.
      if (err) begin
        state_nx = S_CTRL;
        cnt_nx   = (i_mode == M_CTRL) ? 4'd1 : 4'd0;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state      <= S_CTRL;
        cnt        <= 4'd0;
        n          <= 2'd0;
        len        <= 10'd0;
        seq_err_p0 <= 1'b0;
      end else begin
        state      <= state_nx;
        cnt        <= cnt_nx;
        n          <= n_nx;
        len        <= len_nx;
        seq_err_p0 <= seq_err_p0 | err;
      end
    end
  end else begin : g_nochk
    assign seq_err_p0 = 1'b0;
  end

  // ---- stage p0: first output register ----
  logic [10*NUM_CH-1:0] tmds_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) tmds_p0 <= {NUM_CH{SYM_RST}};
    else       tmds_p0 <= sym_c;
  end

  // ---- stage p1: optional second output register ----
  if (PIPE == 2) begin : g_pipe2
    logic [10*NUM_CH-1:0] tmds_p1;
    logic                 seq_err_p1;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        tmds_p1    <= {NUM_CH{SYM_RST}};
        seq_err_p1 <= 1'b0;
      end else begin
        tmds_p1    <= tmds_p0;
        seq_err_p1 <= seq_err_p0;
      end
    end

    assign o_tmds    = tmds_p1;
    assign o_seq_err = seq_err_p1;
  end else begin : g_pipe1
    assign o_tmds    = tmds_p0;
    assign o_seq_err = seq_err_p0;
  end

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// tb_tmds_encoder_hdmi
//   Directed bench for tmds_encoder_hdmi. Three instances share one stimulus:
//   PIPE=1/CHECK=1, PIPE=2/CHECK=1 and PIPE=1/CHECK=0. Expected symbols are
//   hand-computed constants.
module tb_tmds_encoder_hdmi;

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] C10  = 10'b0101010100;
  localparam logic [9:0] C11  = 10'b1010101011;
  localparam logic [9:0] GBH  = 10'b1011001100;
  localparam logic [9:0] GBL  = 10'b0100110011;
  localparam logic [29:0] RST_ALL = {C00, C00, C00};

  localparam logic [9:0] T [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [23:0] data;
  logic [5:0]  ctrl;
  logic [11:0] aux;
  logic [29:0] tmds1, tmds2, tmds_nc;
  logic        err1, err2, err_nc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmds_encoder_hdmi #(.NUM_CH(3), .PIPE(1), .CHECK(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_data(data), .i_ctrl(ctrl),
    .i_aux(aux), .o_tmds(tmds1), .o_seq_err(err1));

  tmds_encoder_hdmi #(.NUM_CH(3), .PIPE(2), .CHECK(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_data(data), .i_ctrl(ctrl),
    .i_aux(aux), .o_tmds(tmds2), .o_seq_err(err2));

  tmds_encoder_hdmi #(.NUM_CH(3), .PIPE(1), .CHECK(0)) dut_nc (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_data(data), .i_ctrl(ctrl),
    .i_aux(aux), .o_tmds(tmds_nc), .o_seq_err(err_nc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [9:0] vseq [4];
    vseq[0] = 10'h100; vseq[1] = 10'h3FF; vseq[2] = 10'h100; vseq[3] = 10'h3FF;

    // Reset held with video inputs present
    rst = 1'b1; mode = 3'd1; data = {3{8'hFF}}; ctrl = 6'b0; aux = 12'h0;
    ticks(2);
    chk("rst_tmds1", tmds1, RST_ALL);
    chk("rst_tmds2", tmds2, RST_ALL);
    chk("rst_err1", 30'(err1), 30'd0);
    chk("rst_err2", 30'(err2), 30'd0);

    // VIDEO D=0x00 straight after reset
    rst = 1'b0; mode = 3'd1; data = 24'h0;
    tick();
    chk("v0_tmds1", tmds1, {3{10'h100}});
    chk("v0_tmds2", tmds2, RST_ALL);
    chk("v0_err1", 30'(err1), 30'd1);
    chk("v0_err2", 30'(err2), 30'd0);
    chk("v0_errnc", 30'(err_nc), 30'd0);
    tick();
    chk("v1_tmds1", tmds1, {3{10'h3FF}});
    chk("v1_tmds2", tmds2, {3{10'h100}});
    chk("v1_err2", 30'(err2), 30'd1);
    tick();
    chk("v2_tmds1", tmds1, {3{10'h100}});
    chk("v2_tmds2", tmds2, {3{10'h3FF}});

    // Legal video period
    mode = 3'd0; ctrl = 6'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(8);
    chk("ctrl_tmds1", tmds1, RST_ALL);
    mode = 3'd2;
    tick();
    chk("vgb0", tmds1, {GBH, GBL, GBH});
    tick();
    chk("vgb1", tmds1, {GBH, GBL, GBH});
    mode = 3'd1; data = {8'h10, 8'h00, 8'h10};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("vid_seq", tmds1, {10'h1F0, vseq[i], 10'h1F0});
    end
    mode = 3'd0;
    tick();
    chk("vid_end_ctrl", tmds1, RST_ALL);
    chk("vid_end_err", 30'(err1), 30'd0);
    ticks(7);
    mode = 3'd2;
    ticks(2);
    mode = 3'd1; data = {3{8'h01}};
    tick();
    chk("vid_bias0", tmds1, {3{10'h1FF}});
    chk("vid_bias0_err", 30'(err1), 30'd0);

    // Data island of 32 TERC4 cycles
    mode = 3'd0; ctrl = 6'b11_10_01;
    ticks(10);
    chk("ctrl_codes", tmds1, {C11, C10, C01});
    mode = 3'd3;
    tick();
    chk("igb_lead0", tmds1, {GBL, GBL, T[13]});
    tick();
    chk("igb_lead1", tmds1, {GBL, GBL, T[13]});
    mode = 3'd4;
    for (int i = 0; i < 32; i++) begin
      aux = {3{4'(i)}};
      tick();
      chk("terc4", tmds1, {3{T[i % 16]}});
    end
    mode = 3'd3;
    tick();
    chk("igb_trail0", tmds1, {GBL, GBL, T[13]});
    tick();
    mode = 3'd0;
    tick();
    chk("island_err1", 30'(err1), 30'd0);
    chk("island_err2", 30'(err2), 30'd0);

    // Data island of 33 cycles: error on first trailing guard band
    ticks(7);
    mode = 3'd3;
    ticks(2);
    mode = 3'd4;
    for (int i = 0; i < 33; i++) begin
      aux = {3{4'(i)}};
      tick();
    end
    chk("island33_pre", 30'(err1), 30'd0);
    mode = 3'd3;
    tick();
    chk("island33_err1", 30'(err1), 30'd1);
    chk("island33_err2", 30'(err2), 30'd0);
    chk("island33_sym", tmds1, {GBL, GBL, T[13]});
    tick();
    chk("island33_err2b", 30'(err2), 30'd1);

    // Reset in the middle of video
    mode = 3'd0; ctrl = 6'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(8);
    mode = 3'd2;
    ticks(2);
    mode = 3'd1; data = 24'h0;
    ticks(2);
    chk("mid_vid", tmds1, {3{10'h3FF}});
    rst = 1'b1;
    tick();
    chk("mid_rst_tmds1", tmds1, RST_ALL);
    chk("mid_rst_tmds2", tmds2, RST_ALL);
    chk("mid_rst_err1", 30'(err1), 30'd0);

    // Reserved mode
    rst = 1'b0; mode = 3'd6; ctrl = 6'b11_10_01;
    tick();
    chk("rsv_tmds1", tmds1, {C11, C10, C01});
    chk("rsv_tmdsnc", tmds_nc, {C11, C10, C01});
    chk("rsv_err1", 30'(err1), 30'd1);
    chk("rsv_errnc", 30'(err_nc), 30'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_hdmi.md
Name: tmds_encoder_hdmi

Overview:
Multi-channel HDMI TMDS encoder. It extends the DVI-only encoder with three extra modes: video guard band, data-island guard band and TERC4 data-island coding. It also has a configurable output pipeline and an HDMI period-sequence checker. The block sits between the HDMI timing/packet generator and the 10:1 serialisers, with one 10-bit symbol per channel per pixel clock.

Parameters:
NUM_CH, 3, number of TMDS channels; channel k uses the guard-band role of channel (k mod 3).
PIPE, 1, output register stages (1 or 2); any other value is a synthesis-time error.
CHECK, 1, 1 enables the sequence checker; 0 ties o_seq_err to 0.

Ports:
i_clk  in  1  pixel clock.
i_rst  in  1  synchronous reset, active-high.
i_mode  in  3  0=CTRL, 1=VIDEO, 2=VIDEO_GB, 3=ISLAND_GB, 4=TERC4, 5..7 reserved.
i_data  in  8*NUM_CH  video byte per channel, channel k in bits [8k+7:8k].
i_ctrl  in  2*NUM_CH  control bits per channel (ch0 = {vsync,hsync}).
i_aux  in  4*NUM_CH  TERC4 nibble per channel.
o_tmds  out  10*NUM_CH  encoded symbol per channel; bit 0 is transmitted first.
o_seq_err  out  1  sticky sequence-violation flag.

Behaviour:
- Reset: every channel's o_tmds = 10'b1101010100 in all pipe stages. All biases = 0. o_seq_err = 0. Checker state = S_CTRL with count 0.
- Latency: o_tmds reflects inputs sampled PIPE cycles earlier. o_seq_err uses the same latency.
- CTRL: ctrl 00/01/10/11 -> 1101010100 / 0010101011 / 0101010100 / 1010101011. Channel bias is cleared.
- VIDEO: standard DVI two-stage coding.
  - XNOR is used if N1(D) > 4, or if N1(D) == 4 and D[0] == 0.
  - Per-channel bias is 5-bit signed and is updated only in VIDEO mode.
  - Invert/bias rules:
    - bias == 0 or balance == 0: {~q_m8, q_m8, q_m8 ? q_m : ~q_m}; bias ± balance.
    - sign(bias) == sign(balance): invert; bias += 2*q_m8 - balance.
    - otherwise: no invert; bias += balance - 2*~q_m8.
- VIDEO_GB: roles 0 and 2 output 1011001100; role 1 outputs 0100110011. Bias is cleared.
- ISLAND_GB: role 0 outputs TERC4({1,1,ctrl[1:0]}); roles 1 and 2 output 0100110011. Bias is cleared.
- TERC4 mode: nibble 0..F maps to 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011. Bias is cleared.
- Reserved modes: encoded as CTRL and flagged as an error.
- Checker FSM states: S_CTRL(cnt, saturating at 8), S_VGB(n), S_VIDEO, S_IGB_LEAD(n), S_ISLAND(len), S_IGB_TRAIL(n).
  - S_CTRL: CTRL increments cnt. VIDEO_GB or ISLAND_GB with cnt < 8 is an error; with cnt == 8 it enters S_VGB or S_IGB_LEAD with n=1. VIDEO or TERC4 from S_CTRL is an error.
  - S_VGB: n=1 requires VIDEO_GB (n=2). n=2 requires VIDEO -> S_VIDEO.
  - S_VIDEO: VIDEO stays. CTRL -> S_CTRL cnt=1. Anything else is an error.
  - S_IGB_LEAD: exactly 2 ISLAND_GB, then TERC4 -> S_ISLAND with len=1.
  - S_ISLAND: TERC4 increments len (10 bits). len > 576 is an error.
    - ISLAND_GB with len a multiple of 32 -> S_IGB_TRAIL n=1; otherwise it is an error.
  - S_IGB_TRAIL: requires one more ISLAND_GB, then CTRL -> S_CTRL cnt=1.
  - On any error: o_seq_err sets until reset. FSM resyncs to S_CTRL with cnt=1 if the mode is CTRL, else cnt=0. Encoding is never altered by the checker.
- Mode change mid-stream takes effect on that cycle's symbol. No cross-cycle state other than bias and the checker.
- Reset mid-operation clears all pipe stages in the same cycle. Outputs show reset values on the next edge.

Test Plan:
- Reset, then VIDEO ch0 D=0x00 twice (bias 0) -> 0x100 with bias -8, then 0x3FF with bias +2. o_seq_err=1 because VIDEO follows CTRL.
- 8 CTRL, 2 VIDEO_GB, 4 VIDEO (D=0x10), then CTRL -> guard symbols 1011001100/0100110011/1011001100, o_seq_err stays 0, bias returns to 0 on CTRL.
- 10 CTRL, 2 ISLAND_GB (ctrl=2'b01), 32 TERC4 with i_aux=0x0..0xF repeating, 2 ISLAND_GB, CTRL -> ch0 guard = TERC4(0xD) = 1001110001. Table values match, no error.
- Island of 33 TERC4 cycles before trailing GB -> o_seq_err rises PIPE cycles after the first trailing GB.
- PIPE=2: same VIDEO stimulus -> identical symbols delayed by one extra cycle. i_rst asserted mid-video -> 1101010100 on all channels the next cycle.
- i_mode=6 -> CTRL code for i_ctrl, o_seq_err=1. With CHECK=0, o_seq_err stays 0.
